// File: rtl/sensor_cfg_pkg.sv
// Shared definitions for the sensor configuration sequencer.
// Holds the FSM state codes, the default delay-marker helper and the LUT entry width helper.
// The LUT entry layout is {addr, data}, with the address in the upper bits.
package sensor_cfg_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DELAY = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

  // All-ones value of the given width, used as the default delay marker address.
  function automatic logic [31:0] all_ones(input int width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Width of one {addr, data} LUT entry.
  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for delay entries: load value times UNIT, count down one per tick.
// 'last' is high in the final tick cycle, so N*UNIT ticks are spent (one tick when N is 0).
// Counter is sized to hold (2^LOAD_W - 1) * UNIT without overflow.
module cfg_delay_timer #(
  parameter int LOAD_W = 8,
  parameter int UNIT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LOAD_W-1:0] load_val,
  input  logic              tick,
  output logic              last
);

  localparam int CNT_W = LOAD_W + $clog2(UNIT + 1);

  logic [CNT_W-1:0] count;

  // Load the scaled delay, then count down towards zero while ticking.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(load_val) * CNT_W'(UNIT);
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // A count of 0 or 1 means this tick is the last one.
  assign last = (count <= CNT_W'(1));

endmodule

// File: rtl/sensor_cfg_sequencer.sv
// Walks an external {addr, data} register LUT, issuing each entry to an I2C master.
// Delay-marker entries wait data*DELAY_UNIT cycles; NACKs are retried up to MAX_RETRY times.
// Optional macro CFG_READBACK_VERIFY_EN: read back every write and retry on mismatch.
module sensor_cfg_sequencer
  import sensor_cfg_pkg::*;
#(
  parameter int                    REG_ADDR_W = 16,
  parameter int                    REG_DATA_W = 8,
  parameter int                    INDEX_W    = 9,
  parameter logic [REG_ADDR_W-1:0] DELAY_ADDR = REG_ADDR_W'(all_ones(REG_ADDR_W)),
  parameter int                    DELAY_UNIT = 1000,
  parameter int                    MAX_RETRY  = 3
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [INDEX_W-1:0]                                  lut_size,
  output logic [INDEX_W-1:0]                                  lut_index,
  input  logic [entry_width(REG_ADDR_W, REG_DATA_W)-1:0]      lut_data,
  output logic                                                req_valid,
  input  logic                                                req_ready,
  output logic                                                req_rw,
  output logic [REG_ADDR_W-1:0]                               req_addr,
  output logic [REG_DATA_W-1:0]                               req_wdata,
  input  logic                                                rsp_valid,
  input  logic                                                rsp_nack,
  input  logic [REG_DATA_W-1:0]                               rsp_rdata,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                error,
  output logic [INDEX_W-1:0]                                  err_index
);

  localparam int ENTRY_W = entry_width(REG_ADDR_W, REG_DATA_W);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [2:0]            state;
  logic [REG_ADDR_W-1:0] ent_addr;
  logic [REG_DATA_W-1:0] ent_data;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [REG_ADDR_W-1:0] lut_addr;
  logic [REG_DATA_W-1:0] lut_wdat;
  logic                  is_delay;
  logic                  delay_last;
  logic                  rb_phase;
  logic                  attempt_fail;
  logic                  need_rb;

  assign lut_addr = lut_data[ENTRY_W-1:REG_DATA_W];
  assign lut_wdat = lut_data[REG_DATA_W-1:0];
  assign is_delay = (lut_addr == DELAY_ADDR);

`ifdef CFG_READBACK_VERIFY_EN
  // A read NACK or a readback mismatch fails the whole write+read attempt.
  assign attempt_fail = rsp_nack || (rb_phase && (rsp_rdata != ent_data));
  assign need_rb      = !rb_phase;

  // Tracks whether the outstanding request is the verifying read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_phase <= 1'b0;
    end else if ((state == ST_WAIT) && rsp_valid) begin
      rb_phase <= !attempt_fail && !rb_phase;
    end else if ((state != ST_WAIT) && (state != ST_ISSUE)) begin
      rb_phase <= 1'b0;
    end
  end
`else
  logic unused_rdata;

  assign attempt_fail = rsp_nack;
  assign need_rb      = 1'b0;
  assign rb_phase     = 1'b0;
  assign unused_rdata = ^rsp_rdata;
`endif

  cfg_delay_timer #(
    .LOAD_W (REG_DATA_W),
    .UNIT   (DELAY_UNIT)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == ST_FETCH) && is_delay),
    .load_val (lut_wdat),
    .tick     (state == ST_DELAY),
    .last     (delay_last)
  );

  assign req_valid = (state == ST_ISSUE);
  assign req_rw    = rb_phase;
  assign req_addr  = ent_addr;
  assign req_wdata = ent_data;
  assign busy      = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT) ||
                     (state == ST_DELAY) || (state == ST_NEXT);

  // Main sequencing FSM, entry register, retry budget and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lut_index <= '0;
      ent_addr  <= '0;
      ent_data  <= '0;
      retry_cnt <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            lut_index <= '0;
            retry_cnt <= '0;
            error     <= 1'b0;
            if (lut_size == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              done  <= 1'b0;
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          ent_addr <= lut_addr;
          ent_data <= lut_wdat;
          state    <= is_delay ? ST_DELAY : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            if (attempt_fail) begin
              if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
                state     <= ST_ISSUE;
              end else begin
                err_index <= lut_index;
                error     <= 1'b1;
                state     <= ST_ERROR;
              end
            end else if (need_rb) begin
              state <= ST_ISSUE;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_DELAY: begin
          if (delay_last) state <= ST_NEXT;
        end
        ST_NEXT: begin
          retry_cnt <= '0;
          if (lut_index == (lut_size - INDEX_W'(1))) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            lut_index <= lut_index + INDEX_W'(1);
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_cfg_sequencer.sv
// Self-checking bench for sensor_cfg_sequencer: directed steps plus randomized tables.
// An I2C responder with random ready/latency/NACK injection drives the DUT; a table-level
// model predicts the full request trace, final status and delay-entry durations.
module tb_sensor_cfg_sequencer;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int IW   = 9;
  localparam int UNIT = 4;
  localparam int MAXR = 3;
  localparam logic [AW-1:0] DADDR = 16'hFFFF;

  typedef struct {
    bit          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          idx;
  } req_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IW-1:0]   lut_size;
  logic [IW-1:0]   lut_index;
  logic [AW+DW-1:0] lut_data;
  logic            req_valid;
  logic            req_ready;
  logic            req_rw;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic            rsp_nack;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic            done;
  logic            error;
  logic [IW-1:0]   err_index;

  logic [AW+DW-1:0] lut_mem [0:511];
  int   fail_cnt [0:511];
  bit   fail_rd  [0:511];
  int   wr_cnt   [0:511];
  int   idx_cyc  [0:511];
  req_t obs_q[$];
  req_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_req = -1;
  int ready_pct = 100;
  int lat_max = 0;
  bit spurious_en = 1'b0;
  bit pend = 1'b0;
  int pend_cnt = 0;
  bit pend_nack = 1'b0;
  logic [DW-1:0] pend_rdata = '0;

  always #5 clk = ~clk;

  assign lut_data = lut_mem[lut_index];

  sensor_cfg_sequencer #(
    .REG_ADDR_W (AW),
    .REG_DATA_W (DW),
    .INDEX_W    (IW),
    .DELAY_UNIT (UNIT),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lut_size  (lut_size),
    .lut_index (lut_index),
    .lut_data  (lut_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input req_t r);
    return {30'd0, r.rw, r.addr, r.data, IW'(r.idx)};
  endfunction

  // One clock: sample DUT just after the edge, then drive the responder for the next edge.
  task automatic step();
    req_t r;
    int   a;
    @(posedge clk);
    #1;
    cyc++;
    if (busy) idx_cyc[lut_index]++;
    if (req_valid && (first_req < 0)) first_req = cyc - start_cyc;
    rsp_valid = 1'b0;
    rsp_nack  = 1'($urandom_range(0, 1));
    rsp_rdata = DW'($urandom);
    if (pend) begin
      if (pend_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_nack  = pend_nack;
        rsp_rdata = pend_rdata;
        pend      = 1'b0;
      end else begin
        pend_cnt--;
      end
    end else if (spurious_en && ($urandom_range(0, 7) == 0)) begin
      rsp_valid = 1'b1;
    end
    req_ready = !pend && (int'($urandom_range(1, 100)) <= ready_pct);
    if (req_valid && req_ready && !rst) begin
      r.rw   = req_rw;
      r.addr = req_addr;
      r.data = req_rw ? '0 : req_wdata;
      r.idx  = int'(lut_index);
      obs_q.push_back(r);
      if (!req_rw) begin
        a = wr_cnt[lut_index];
        wr_cnt[lut_index]++;
        pend_nack  = (a < fail_cnt[lut_index]) && !fail_rd[lut_index];
        pend_rdata = DW'($urandom);
      end else begin
        a = wr_cnt[lut_index] - 1;
        pend_nack  = 1'b0;
        pend_rdata = lut_mem[lut_index][DW-1:0] ^ ((a < fail_cnt[lut_index]) ? 8'h01 : 8'h00);
      end
      pend     = 1'b1;
      pend_cnt = $urandom_range(0, lat_max);
    end
  endtask

  // Table-level model: expected request trace; returns failing index or -1.
  function automatic int build_expect(input int size);
    exp_q.delete();
    for (int i = 0; i < size; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int tries;
      bit fails;
      a = lut_mem[i][AW+DW-1:DW];
      d = lut_mem[i][DW-1:0];
      if (a == DADDR) continue;
      fails = (fail_cnt[i] > MAXR);
      tries = fails ? (MAXR + 1) : (fail_cnt[i] + 1);
      for (int t = 0; t < tries; t++) begin
        exp_q.push_back('{rw: 1'b0, addr: a, data: d, idx: i});
`ifdef CFG_READBACK_VERIFY_EN
        if (!((t < fail_cnt[i]) && !fail_rd[i]))
          exp_q.push_back('{rw: 1'b1, addr: a, data: DW'(0), idx: i});
`endif
      end
      if (fails) return i;
    end
    return -1;
  endfunction

  task automatic begin_seq(input int size);
    obs_q.delete();
    for (int i = 0; i < 512; i++) begin
      wr_cnt[i]  = 0;
      idx_cyc[i] = 0;
    end
    lut_size  = IW'(size);
    first_req = -1;
    start_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_seq(input int size, input bit rnd, input string tag, output int exp_err);
    int n;
    exp_err = build_expect(size);
    begin_seq(size);
    n = 0;
    while (!(done || error) && (n < 4000)) begin
      if (rnd) start = ($urandom_range(0, 15) == 0);
      step();
      start = 1'b0;
      n++;
    end
    check({tag, " timeout"}, n < 4000, 1'b1);
    check({tag, " done"}, done, exp_err < 0);
    check({tag, " error"}, error, exp_err >= 0);
    check({tag, " busy"}, busy, 1'b0);
    if (exp_err >= 0) check({tag, " err_index"}, err_index, IW'(exp_err));
    check({tag, " req_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; (i < obs_q.size()) && (i < exp_q.size()); i++)
      check({tag, " req"}, pk(obs_q[i]), pk(exp_q[i]));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " lut_index"}, lut_index, '0);
    check({tag, " req_valid"}, req_valid, 1'b0);
    check({tag, " req_rw"}, req_rw, 1'b0);
    check({tag, " req_addr"}, req_addr, '0);
    check({tag, " req_wdata"}, req_wdata, '0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " error"}, error, 1'b0);
    check({tag, " err_index"}, err_index, '0);
  endtask

  function automatic int count_idx(input int idx);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i].idx == idx) c++;
    return c;
  endfunction

  initial begin
    int ee;
    int k;
    rst = 1'b1; start = 1'b0; lut_size = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = '0;
    for (int i = 0; i < 512; i++) begin
      lut_mem[i] = '0; fail_cnt[i] = 0; fail_rd[i] = 1'b0; wr_cnt[i] = 0; idx_cyc[i] = 0;
    end
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;

    // Three plain writes, ready always high, all ACK.
    lut_mem[0] = {16'h3008, 8'h82};
    lut_mem[1] = {16'h3103, 8'h03};
    lut_mem[2] = {16'h3017, 8'h7F};
    lut_mem[3] = {16'h3820, 8'h41};
    run_seq(3, 1'b0, "three", ee);
    check("start_to_req_valid", first_req, 2);

    // Delay marker in the middle: FETCH + 5*UNIT delay cycles + NEXT at index 1.
    lut_mem[1] = {DADDR, 8'd5};
    run_seq(3, 1'b0, "delay", ee);
    check("delay_cycles", idx_cyc[1], 5 * UNIT + 2);
    check("delay_no_req", count_idx(1), 0);

    // Entry 1 NACKs twice then ACKs.
    lut_mem[1] = {16'h3103, 8'h03};
    fail_cnt[1] = 2;
    run_seq(4, 1'b0, "nack2", ee);
    check("nack2_idx1_reqs", count_idx(1), 3);

    // Entry 2 NACKs four times: error at 2, nothing for 3; then a clean restart.
    fail_cnt[1] = 0;
    fail_cnt[2] = 4;
    run_seq(4, 1'b0, "nack4", ee);
    check("nack4_idx3_reqs", count_idx(3), 0);
    fail_cnt[2] = 0;
    run_seq(4, 1'b0, "restart", ee);
    check("restart_first_idx", (obs_q.size() > 0) ? obs_q[0].idx : -1, 0);

    // Empty table finishes immediately.
    run_seq(0, 1'b0, "empty", ee);

`ifdef CFG_READBACK_VERIFY_EN
    // First readback of entry 0 returns data^1: one extra write+read pair.
    fail_cnt[0] = 1;
    fail_rd[0]  = 1'b1;
    run_seq(3, 1'b0, "readback", ee);
    check("readback_idx0_reqs", count_idx(0), 4);
    fail_cnt[0] = 0;
    fail_rd[0]  = 1'b0;
`endif

    // Reset while waiting for a response, then restart.
    for (int i = 0; i < 5; i++) lut_mem[i] = {AW'(16'h4000 + i), DW'(8'h10 + i)};
    lat_max = 8;
    void'(build_expect(5));
    begin_seq(5);
    k = 0;
    while ((obs_q.size() == 0) && (k < 200)) begin
      step();
      k++;
    end
    check("rst_wait accepted", k < 200, 1'b1);
    step();
    check("rst_wait busy", busy, 1'b1);
    check("rst_wait req_valid", req_valid, 1'b0);
    rst = 1'b1;
    step();
    check_reset("mid_rst");
    rst = 1'b0;
    repeat (12) step();
    check("post_rst idle", busy, 1'b0);
    check("post_rst done", done, 1'b0);
    run_seq(5, 1'b0, "after_rst", ee);

    // Randomized tables, ready stalls, latencies, NACKs, stray responses, ignored starts.
    spurious_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int size;
      size      = $urandom_range(1, 10);
      ready_pct = $urandom_range(30, 100);
      lat_max   = $urandom_range(0, 4);
      for (int i = 0; i < size; i++) begin
        logic [AW-1:0] a;
        if ($urandom_range(0, 4) == 0) begin
          lut_mem[i] = {DADDR, DW'($urandom_range(0, 3))};
        end else begin
          a = AW'($urandom);
          if (a == DADDR) a[0] = 1'b0;
          lut_mem[i] = {a, DW'($urandom)};
        end
        fail_cnt[i] = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
`ifdef CFG_READBACK_VERIFY_EN
        fail_rd[i] = 1'($urandom_range(0, 1));
`else
        fail_rd[i] = 1'b0;
`endif
      end
      run_seq(size, 1'b1, "random", ee);
      for (int i = 0; i < size; i++) begin
        if ((ee >= 0) && (i > ee)) break;
        if (lut_mem[i][AW+DW-1:DW] == DADDR) begin
          int dly;
          dly = int'(lut_mem[i][DW-1:0]) * UNIT;
          if (dly < 1) dly = 1;
          check("random delay_cycles", idx_cyc[i], dly + 2);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
